// File: rtl/mpu6050_sampler.sv
// mpu6050_sampler: drives the I2C register-interface bus to wake the MPU-6050
// once after reset, then read accel (and optionally gyro) bytes and assemble
// them into signed 16-bit big-endian axis values with a one-cycle valid strobe.
// Optional feature: define MPU_GYRO_READ_EN to also read gyro X/Y/Z (8'h43..8'h48).
module mpu6050_sampler #(
  parameter logic [6:0]  SLAVE_ADDR  = 7'h68,
  parameter int unsigned WAIT_CYCLES = 2000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        sample_valid,
  output logic [15:0] ax,
  output logic [15:0] ay,
  output logic [15:0] az,
  output logic [15:0] gx,
  output logic [15:0] gy,
  output logic [15:0] gz,
  output logic [2:0]  reg_address,
  output logic [7:0]  reg_write_data,
  output logic        reg_we,
  output logic        reg_re,
  input  logic [7:0]  reg_read_data
);

`ifdef MPU_GYRO_READ_EN
  localparam int unsigned NUM_BYTES = 12;
`else
  localparam int unsigned NUM_BYTES = 6;
`endif
  localparam int unsigned IDX_W = 4;
  localparam int unsigned CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES);

  localparam logic [2:0] REG_ENABLE   = 3'd0;
  localparam logic [2:0] REG_SLAVE    = 3'd1;
  localparam logic [2:0] REG_RW       = 3'd2;
  localparam logic [2:0] REG_REGADDR  = 3'd3;
  localparam logic [2:0] REG_DATA_IN  = 3'd4;
  localparam logic [2:0] REG_DATA_OUT = 3'd5;

  typedef enum logic [3:0] {
    S_IDLE, S_LD_SA, S_LD_RW, S_LD_RA, S_LD_DI, S_EN_SET,
    S_WAIT, S_EN_CLR, S_RD_REQ, S_RD_CAP, S_NEXT, S_DONE
  } state_t;

  state_t state, state_next;

  // idx 0 is the PWR_MGMT_1 wake write; idx 1..NUM_BYTES are byte reads
  logic [IDX_W-1:0]            idx;
  logic [CNT_W-1:0]            cnt;
  logic                        woken;
  logic [NUM_BYTES-1:0][7:0]   byte_q;
  logic                        is_read;
  logic [7:0]                  reg_ra;

  logic        busy_d, valid_d, we_d, re_d;
  logic [2:0]  addr_d;
  logic [7:0]  wdata_d;

  // Register address and direction of the current transaction
  always_comb begin
    is_read = (idx != '0);
    if (idx == '0)
      reg_ra = 8'h6B;
    else if (idx <= IDX_W'(6))
      reg_ra = 8'h3A + 8'(idx);
    else
      reg_ra = 8'h3C + 8'(idx);
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (start) state_next = S_LD_SA;
      S_LD_SA:  state_next = S_LD_RW;
      S_LD_RW:  state_next = S_LD_RA;
      S_LD_RA:  state_next = S_LD_DI;
      S_LD_DI:  state_next = S_EN_SET;
      S_EN_SET: state_next = (WAIT_CYCLES > 1) ? S_WAIT : S_EN_CLR;
      S_WAIT:   if (cnt == CNT_W'(1)) state_next = S_EN_CLR;
      S_EN_CLR: state_next = is_read ? S_RD_REQ : S_NEXT;
      S_RD_REQ: state_next = S_RD_CAP;
      S_RD_CAP: state_next = S_NEXT;
      S_NEXT:   state_next = (idx == LAST_IDX) ? S_DONE : S_LD_SA;
      S_DONE:   state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // Output decode from the upcoming state so registered outputs align with it
  always_comb begin
    busy_d  = (state_next != S_IDLE);
    valid_d = (state_next == S_DONE);
    we_d    = 1'b0;
    re_d    = 1'b0;
    addr_d  = '0;
    wdata_d = '0;
    case (state_next)
      S_LD_SA:  begin we_d = 1'b1; addr_d = REG_SLAVE;    wdata_d = {1'b0, SLAVE_ADDR}; end
      S_LD_RW:  begin we_d = 1'b1; addr_d = REG_RW;       wdata_d = {7'd0, is_read}; end
      S_LD_RA:  begin we_d = 1'b1; addr_d = REG_REGADDR;  wdata_d = reg_ra; end
      S_LD_DI:  begin we_d = 1'b1; addr_d = REG_DATA_IN;  wdata_d = 8'h00; end
      S_EN_SET: begin we_d = 1'b1; addr_d = REG_ENABLE;   wdata_d = 8'h01; end
      S_EN_CLR: begin we_d = 1'b1; addr_d = REG_ENABLE;   wdata_d = 8'h00; end
      S_RD_REQ: begin re_d = 1'b1; addr_d = REG_DATA_OUT; end
      default: ;
    endcase
  end

  // Registered bus and status outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy           <= 1'b0;
      sample_valid   <= 1'b0;
      reg_we         <= 1'b0;
      reg_re         <= 1'b0;
      reg_address    <= '0;
      reg_write_data <= '0;
    end else begin
      busy           <= busy_d;
      sample_valid   <= valid_d;
      reg_we         <= we_d;
      reg_re         <= re_d;
      reg_address    <= addr_d;
      reg_write_data <= wdata_d;
    end
  end

  // Transaction index, wait counter, wake flag and byte capture
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx    <= '0;
      cnt    <= '0;
      woken  <= 1'b0;
      byte_q <= '0;
    end else begin
      case (state)
        S_IDLE:   if (start) idx <= woken ? IDX_W'(1) : '0;
        S_EN_SET: cnt <= CNT_W'(WAIT_CYCLES - 1);
        S_WAIT:   cnt <= cnt - CNT_W'(1);
        S_RD_CAP: begin
          for (int i = 0; i < NUM_BYTES; i++)
            if (idx == IDX_W'(i + 1)) byte_q[i] <= reg_read_data;
        end
        S_NEXT: begin
          idx <= idx + IDX_W'(1);
          if (idx == '0) woken <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Axis assembly, first byte is the high byte
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ax <= '0;
      ay <= '0;
      az <= '0;
`ifdef MPU_GYRO_READ_EN
      gx <= '0;
      gy <= '0;
      gz <= '0;
`endif
    end else if (state_next == S_DONE) begin
      ax <= {byte_q[0], byte_q[1]};
      ay <= {byte_q[2], byte_q[3]};
      az <= {byte_q[4], byte_q[5]};
`ifdef MPU_GYRO_READ_EN
      gx <= {byte_q[6],  byte_q[7]};
      gy <= {byte_q[8],  byte_q[9]};
      gz <= {byte_q[10], byte_q[11]};
`endif
    end
  end

`ifndef MPU_GYRO_READ_EN
  assign gx = 16'h0000;
  assign gy = 16'h0000;
  assign gz = 16'h0000;
`endif

endmodule

// File: tb/tb_mpu6050_sampler.sv
// tb_mpu6050_sampler: directed bench for mpu6050_sampler with a register-level
// slave model standing in for the I2C block and the MPU-6050 register file.
`timescale 1ns/1ps
module tb_mpu6050_sampler;

  localparam int unsigned WC = 4;
`ifdef MPU_GYRO_READ_EN
  localparam int EXTRA = 6 * (WC + 8);
  localparam logic [15:0] EXP_G = 16'h8000;
`else
  localparam int EXTRA = 0;
  localparam logic [15:0] EXP_G = 16'h0000;
`endif
  localparam int LAT_WOKEN = 6 * (WC + 8) + 1 + EXTRA;
  localparam int LAT_FIRST = LAT_WOKEN + WC + 6;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        busy, sample_valid;
  logic [15:0] ax, ay, az, gx, gy, gz;
  logic [2:0]  reg_address;
  logic [7:0]  reg_write_data;
  logic        reg_we, reg_re;
  logic [7:0]  reg_read_data;

  mpu6050_sampler #(.SLAVE_ADDR(7'h68), .WAIT_CYCLES(WC)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .sample_valid(sample_valid),
    .ax(ax), .ay(ay), .az(az), .gx(gx), .gy(gy), .gz(gz),
    .reg_address(reg_address), .reg_write_data(reg_write_data),
    .reg_we(reg_we), .reg_re(reg_re), .reg_read_data(reg_read_data)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       rd;
    logic [2:0] addr;
    logic [7:0] data;
  } bus_ev_t;

  typedef struct {
    logic [47:0] data;
    logic [15:0] ex, ey, ez;
    int          lat;
  } vec_t;

  logic [7:0] mem [0:255];
  logic [7:0] ra_q;
  bus_ev_t    bus_log [$];
  int         bad_strobe = 0;
  int         n_pass = 0;
  int         n_total = 0;

  // Slave model: latches REGISTER_ADDRESS writes, returns mem[ra] the cycle after re
  always @(posedge clk) begin
    if (reg_we) begin
      bus_log.push_back({1'b0, reg_address, reg_write_data});
      if (reg_address == 3'd3) ra_q <= reg_write_data;
    end
    if (reg_re) begin
      bus_log.push_back({1'b1, 3'd5, 8'h00});
      reg_read_data <= mem[ra_q];
    end
  end

  // Strobe exclusivity and quiet bus when not busy
  always @(negedge clk) begin
    if (rst && ((reg_we && reg_re) || (!busy && (reg_we || reg_re))))
      bad_strobe++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %0h required %0h", name, act, exp);
  endtask

  function automatic logic [7:0] first_ra(input int base);
    for (int i = base; i < bus_log.size(); i++)
      if (!bus_log[i].rd && bus_log[i].addr == 3'd3) return bus_log[i].data;
    return 8'hEE;
  endfunction

  function automatic int count_wake(input int base);
    int n = 0;
    for (int i = base; i < bus_log.size(); i++)
      if (!bus_log[i].rd && bus_log[i].addr == 3'd3 && bus_log[i].data == 8'h6B) n++;
    return n;
  endfunction

  task automatic load_accel(input logic [47:0] d);
    logic [47:0] tmp;
    tmp = d;
    for (int i = 0; i < 6; i++) mem[8'h3B + i] = tmp[47 - 8*i -: 8];
  endtask

  // Pulse start for one cycle and count cycles until sample_valid
  task automatic start_and_wait(output int lat);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    lat = 1;
    while (!sample_valid && lat < 2000) begin
      @(negedge clk); lat++;
    end
  endtask

  vec_t    vecs [4];
  bus_ev_t exp_seq [13];

  initial begin
    int lat, base, nvalid, lat1, lat2, k;

    vecs[0] = '{48'h1234_FFFE_4000, 16'h1234, 16'hFFFE, 16'h4000, LAT_FIRST};
    vecs[1] = '{48'h0000_0000_0000, 16'h0000, 16'h0000, 16'h0000, LAT_WOKEN};
    vecs[2] = '{48'h8000_7FFF_0102, 16'h8000, 16'h7FFF, 16'h0102, LAT_WOKEN};
    vecs[3] = '{48'hFFFF_0001_ABCD, 16'hFFFF, 16'h0001, 16'hABCD, LAT_WOKEN};

    exp_seq = '{ {1'b0,3'd1,8'h68}, {1'b0,3'd2,8'h00}, {1'b0,3'd3,8'h6B}, {1'b0,3'd4,8'h00},
                 {1'b0,3'd0,8'h01}, {1'b0,3'd0,8'h00}, {1'b0,3'd1,8'h68}, {1'b0,3'd2,8'h01},
                 {1'b0,3'd3,8'h3B}, {1'b0,3'd4,8'h00}, {1'b0,3'd0,8'h01}, {1'b0,3'd0,8'h00},
                 {1'b1,3'd5,8'h00} };

    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    for (int i = 0; i < 3; i++) begin
      mem[8'h43 + 2*i] = 8'h80;
      mem[8'h44 + 2*i] = 8'h00;
    end

    rst = 1'b0; start = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_ctrl", 32'({busy, sample_valid, reg_we, reg_re, reg_address, reg_write_data}), 32'h0);
    check("reset_axy",  {ax, ay}, 32'h0);
    check("reset_azgx", {az, gx}, 32'h0);
    check("reset_gygz", {gy, gz}, 32'h0);
    rst = 1'b1;
    @(negedge clk);

    // Table-driven samples; vector 0 is the first after reset and includes the wake write
    for (int v = 0; v < 4; v++) begin
      load_accel(vecs[v].data);
      base = bus_log.size();
      start_and_wait(lat);
      check($sformatf("v%0d_latency", v), 32'(lat), 32'(vecs[v].lat));
      check($sformatf("v%0d_ax", v), 32'(ax), 32'(vecs[v].ex));
      check($sformatf("v%0d_ay", v), 32'(ay), 32'(vecs[v].ey));
      check($sformatf("v%0d_az", v), 32'(az), 32'(vecs[v].ez));
      check($sformatf("v%0d_gyro", v), {gx, gy}, {EXP_G, EXP_G});
      check($sformatf("v%0d_gz", v), 32'(gz), 32'(EXP_G));
      if (v == 0) begin
        for (int j = 0; j < 13; j++)
          check($sformatf("wake_seq%0d", j),
                (base + j < bus_log.size()) ? 32'(bus_log[base + j]) : 32'hDEAD,
                32'(exp_seq[j]));
      end else begin
        check($sformatf("v%0d_first_ra", v), 32'(first_ra(base)), 32'h3B);
        check($sformatf("v%0d_no_wake", v), 32'(count_wake(base)), 32'd0);
      end
      @(negedge clk);
      check($sformatf("v%0d_valid_pulse", v), 32'({sample_valid, busy}), 32'h0);
    end

    // start pulses during busy are ignored
    load_accel(48'h1234_FFFE_4000);
    @(negedge clk); start = 1'b1;
    nvalid = 0; lat1 = 0;
    for (int c = 1; c <= 400; c++) begin
      @(negedge clk);
      start = (c == 5 || c == 20 || c == 50);
      if (sample_valid) begin
        nvalid++;
        if (lat1 == 0) lat1 = c;
      end
    end
    start = 1'b0;
    check("busy_ign_count", 32'(nvalid), 32'd1);
    check("busy_ign_latency", 32'(lat1), 32'(LAT_WOKEN));
    check("busy_ign_idle", 32'(busy), 32'd0);

    // Asynchronous reset during WAIT of the first read transaction
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    k = 0;
    while (!(reg_we && reg_address == 3'd0 && reg_write_data == 8'h01) && k < 200) begin
      @(negedge clk); k++;
    end
    check("en_set_seen", 32'(k < 200), 32'd1);
    @(negedge clk);
    check("mid_wait_busy", 32'({busy, reg_we, reg_re}), 32'h4);
    #2 rst = 1'b0;
    #1;
    check("rst_async_ctrl", 32'({busy, sample_valid, reg_we, reg_re, reg_address, reg_write_data}), 32'h0);
    check("rst_async_axy", {ax, ay}, 32'h0);
    check("rst_async_az", 32'(az), 32'h0);
    @(negedge clk); rst = 1'b1;

    // Re-wake after reset
    load_accel(48'h0102_0304_0506);
    base = bus_log.size();
    start_and_wait(lat);
    check("rewake_latency", 32'(lat), 32'(LAT_FIRST));
    check("rewake_first_ra", 32'(first_ra(base)), 32'h6B);
    check("rewake_ax", {ax, ay}, 32'h0102_0304);
    check("rewake_az", 32'(az), 32'h0506);

    // start held high: back-to-back samples one IDLE cycle apart
    @(negedge clk); start = 1'b1;
    lat1 = 0; lat2 = 0;
    for (int c = 1; c <= 600 && lat2 == 0; c++) begin
      @(negedge clk);
      if (sample_valid) begin
        if (lat1 == 0) lat1 = c;
        else begin lat2 = c; start = 1'b0; end
      end
    end
    start = 1'b0;
    check("held_first", 32'(lat1), 32'(LAT_WOKEN));
    check("held_spacing", 32'(lat2 - lat1), 32'(LAT_WOKEN + 1));
    repeat (3) @(negedge clk);
    check("held_stop_idle", 32'(busy), 32'd0);

    check("strobe_exclusive", 32'(bad_strobe), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mpu6050_sampler.md
# mpu6050_sampler

Sequencer that sits directly upstream of the I2C register-interface block and drives its register bus (address / write_data / we / re / read_data) to wake the MPU-6050 and read accelerometer samples. On each `start` it programs slave address, direction, register address and data, pulses the master enable, waits a fixed transaction time, and collects result bytes from DATA_OUT. It assembles big-endian byte pairs into signed 16-bit axis values and presents them with a one-cycle valid strobe.

## Interface
Parameters:
- `SLAVE_ADDR`, 7'h68, MPU-6050 7-bit I2C address.
- `WAIT_CYCLES`, 2000, clk cycles held with enable=1 per I2C transaction (≥1).

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-low reset (0 = reset).
- `start`  in  1  request one sample; sampled only in IDLE.
- `busy`  out  1  high from accepted `start` until the cycle after `sample_valid`.
- `sample_valid`  out  1  one-cycle pulse; axis outputs updated same cycle.
- `ax`, `ay`, `az`  out  16 each  signed accel X/Y/Z, held between samples.
- `gx`, `gy`, `gz`  out  16 each  signed gyro X/Y/Z (see Configuration).
- `reg_address`  out  3  register select to I2C block (0 ENABLE, 1 SLAVE_ADDRESS, 2 READ_WRITE, 3 REGISTER_ADDRESS, 4 DATA_IN, 5 DATA_OUT).
- `reg_write_data`  out  8  write data to I2C block.
- `reg_we`  out  1  write strobe, one cycle per register write.
- `reg_re`  out  1  read strobe for DATA_OUT.
- `reg_read_data`  in  8  read data from I2C block.

## Operation
- Reset values: all outputs 0; internal `woken` flag 0; state IDLE.
- READ_WRITE encoding: 1 = read, 0 = write.
- Transaction list per `start`: if `woken`=0, first a write of 8'h00 to reg 8'h6B (PWR_MGMT_1), then set `woken`=1; then reads of 8'h3B..8'h40 (accel XH, XL, YH, YL, ZH, ZL).
- Per-transaction states: LD_SA (write SLAVE_ADDR) -> LD_RW -> LD_RA -> LD_DI (data byte; 8'h00 for reads) -> EN_SET (ENABLE=1) -> WAIT (counter WAIT_CYCLES-1 down to 0) -> EN_CLR (ENABLE=0) -> for reads: RD_REQ (reg_address=5, reg_re=1) -> RD_CAP (store reg_read_data into byte slot) -> NEXT.
- NEXT: advance index; if more transactions go to LD_SA, else DONE.
- DONE: update ax={b0,b1}, ay={b2,b3}, az={b4,b5} (first byte high), assert `sample_valid`, return to IDLE.
- Exactly one of reg_we/reg_re high in any cycle; both 0 in IDLE, WAIT, NEXT, RD_CAP, DONE.
- `start` while busy ignored; `start` held high in IDLE begins a new sample every pass.
- Reset mid-operation: abort immediately, outputs to reset values, `woken` cleared (next start re-wakes). I2C block must be reset concurrently by the integrating top level.

## Timing
- Write transaction: WAIT_CYCLES+5 cycles (LD_SA..EN_CLR) +1 NEXT.
- Read transaction: WAIT_CYCLES+7 cycles +1 NEXT.
- `start` accepted cycle T (IDLE); LD_SA at T+1.
- Latency start->sample_valid (woken, accel only): 6×(WAIT_CYCLES+8)+1 cycles; add WAIT_CYCLES+6 on first sample after reset.
- reg_read_data captured the cycle after reg_re (I2C block latches on re).

## Configuration
- `MPU_GYRO_READ_EN` defined: read list extends to 8'h43..8'h48 after accel; gx/gy/gz assembled from those six bytes and updated on `sample_valid`; latency adds 6×(WAIT_CYCLES+8).
- Undefined: gyro transactions and byte storage removed; gx/gy/gz tied to 16'h0000.

## Test plan
- Reset: rst=0 asynchronously mid-WAIT -> all outputs 0 same edge, busy=0, reg_we=0.
- First start, WAIT_CYCLES=4: reg_we sequence shows addr1=8'h68, addr2=0, addr3=8'h6B, addr4=8'h00, addr0=1, then addr0=0 before any read transaction.
- Slave model returns 8'h12,8'h34,8'hFF,8'hFE,8'h40,8'h00 -> ax=16'h1234, ay=-2, az=16'h4000, one-cycle sample_valid, latency per Timing.
- Second start: no PWR_MGMT_1 write; first register address written is 8'h3B; latency 6×12+1=73 cycles.
- Start pulsed while busy -> ignored, exactly one sample_valid.
- With MPU_GYRO_READ_EN, gyro bytes 8'h80,8'h00 ×3 -> gx=gy=gz=16'h8000; without, gx=gy=gz=0.
